// File: rtl/multi_button_conditioner_pkg.sv
// Shared definitions for the multi-channel pushbutton conditioner.
// Holds the per-channel FSM state encoding, default lockout constants and
// the counter-width legality check used at elaboration.
package multi_button_conditioner_pkg;

    // 2'd3 is unused; the channel FSM recovers from it to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOCK     = 2'd1,
        ST_WAIT_REL = 2'd2
    } btn_state_t;

    localparam int unsigned DEFAULT_CNT_W       = 30;
    // 0.2 s at 50 MHz
    localparam int unsigned DEFAULT_LOCK_PERIOD = 10_000_000;

    // True when period is at least 1 and period-1 fits in cnt_w bits.
    function automatic bit lock_fits(input int unsigned cnt_w, input int unsigned period);
        logic [63:0] load;
        load = 64'(period) - 64'd1;
        return (period >= 1) && ((load >> cnt_w) == 64'd0);
    endfunction

endpackage

// File: rtl/multi_button_conditioner_channel.sv
// One pushbutton channel: 2-FF synchroniser, one-shot pulse, lockout
// counter, re-arm after release, and a toggle or held-state level output.
// Ports:
//   qzt_clk  system clock, rising edge
//   reset    synchronous active-high reset
//   btn_in   raw asynchronous button, active-high
//   pulse    one-cycle press pulse (registered)
//   level    toggle state (TOGGLE=1) or debounced held state (TOGGLE=0)
//   busy     high during lockout and while waiting for release
module button_channel
    import multi_button_conditioner_pkg::*;
#(
    parameter int unsigned CNT_W       = DEFAULT_CNT_W,
    parameter int unsigned LOCK_PERIOD = DEFAULT_LOCK_PERIOD,
    parameter bit          TOGGLE      = 1'b1
) (
    input  logic qzt_clk,
    input  logic reset,
    input  logic btn_in,
    output logic pulse,
    output logic level,
    output logic busy
);

    // Reject a counter that cannot hold LOCK_PERIOD-1.
    if (!lock_fits(CNT_W, LOCK_PERIOD)) begin : g_bad_cnt_w
        $error("button_channel: CNT_W=%0d cannot hold LOCK_PERIOD-1 (LOCK_PERIOD=%0d)",
               CNT_W, LOCK_PERIOD);
    end

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(LOCK_PERIOD - 1);

    logic             s1;
    logic             s2;
    btn_state_t       state;
    btn_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pulse_nxt;
    logic             level_nxt;
    logic             busy_nxt;

    // Synchroniser, state and registered outputs.
    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= ST_IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
            level <= 1'b0;
            busy  <= 1'b0;
        end else begin
            s1    <= btn_in;
            s2    <= s1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pulse <= pulse_nxt;
            level <= level_nxt;
            busy  <= busy_nxt;
        end
    end

    // Next-state and next-output logic; only the synchronised s2 is observed.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        level_nxt = level;
        busy_nxt  = busy;

        case (state)
            ST_IDLE: begin
                busy_nxt = 1'b0;
                if (s2) begin
                    pulse_nxt = 1'b1;
                    cnt_nxt   = LOAD;
                    busy_nxt  = 1'b1;
                    level_nxt = TOGGLE ? ~level : 1'b1;
                    state_nxt = ST_LOCK;
                end
            end
            ST_LOCK: begin
                busy_nxt = 1'b1;
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt = ST_WAIT_REL;
                end
            end
            ST_WAIT_REL: begin
                busy_nxt = 1'b1;
                if (!s2) begin
                    busy_nxt  = 1'b0;
                    state_nxt = ST_IDLE;
                    if (!TOGGLE) begin
                        level_nxt = 1'b0;
                    end
                end
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/multi_button_conditioner.sv
// N-channel pushbutton conditioner: independent button_channel per input.
// Ports:
//   qzt_clk  system clock, rising edge
//   reset    synchronous active-high reset
//   btn_in   raw asynchronous buttons, active-high, N_CH wide
//   pulse    one-cycle press pulse per channel
//   level    per-channel toggle or held state, selected by TOGGLE_MASK
//   busy     per-channel lockout / wait-for-release indicator
module multi_button_conditioner
    import multi_button_conditioner_pkg::*;
#(
    parameter int unsigned          N_CH        = 3,
    parameter int unsigned          CNT_W       = DEFAULT_CNT_W,
    parameter int unsigned          LOCK_PERIOD = DEFAULT_LOCK_PERIOD,
    parameter logic [N_CH-1:0]      TOGGLE_MASK = {N_CH{1'b1}}
) (
    input  logic            qzt_clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] pulse,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] busy
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_channel #(
            .CNT_W       (CNT_W),
            .LOCK_PERIOD (LOCK_PERIOD),
            .TOGGLE      (TOGGLE_MASK[i])
        ) u_ch (
            .qzt_clk (qzt_clk),
            .reset   (reset),
            .btn_in  (btn_in[i]),
            .pulse   (pulse[i]),
            .level   (level[i]),
            .busy    (busy[i])
        );
    end

endmodule

// File: tb/tb_multi_button_conditioner.sv
// Directed bench for multi_button_conditioner (N_CH=3, LOCK_PERIOD=8,
// TOGGLE_MASK=3'b101). Expected pulse events are queued when a press is
// driven and compared when the DUT fires.
module tb_multi_button_conditioner;

    localparam int unsigned N_CH        = 3;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned LOCK_PERIOD = 8;
    localparam logic [2:0]  TMASK       = 3'b101;

    logic       qzt_clk = 1'b0;
    logic       reset;
    logic [2:0] btn_in;
    logic [2:0] pulse;
    logic [2:0] level;
    logic [2:0] busy;

    typedef struct {
        int         cyc;
        logic [2:0] pulse;
        logic [2:0] level;
    } exp_t;

    exp_t       sb[$];
    int         cyc      = 0;
    int         n_pass   = 0;
    int         n_total  = 0;
    logic [2:0] exp_level = 3'b000;

    multi_button_conditioner #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .LOCK_PERIOD (LOCK_PERIOD),
        .TOGGLE_MASK (TMASK)
    ) dut (
        .qzt_clk (qzt_clk),
        .reset   (reset),
        .btn_in  (btn_in),
        .pulse   (pulse),
        .level   (level),
        .busy    (busy)
    );

    always #5 qzt_clk = ~qzt_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock, then sample on the falling edge and score pulses.
    task automatic tick();
        exp_t e;
        @(posedge qzt_clk);
        cyc++;
        @(negedge qzt_clk);
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check("pulse_cycle", 32'(cyc), 32'(e.cyc));
            check("pulse_vec", 32'(pulse), 32'(e.pulse));
            check("level_at_pulse", 32'(level), 32'(e.level));
        end else if (pulse !== 3'b000) begin
            check("unexpected_pulse", 32'(pulse), 32'd0);
        end
    endtask

    // Press channels in mask from idle; pulse expected on the third edge.
    task automatic press(input logic [2:0] mask);
        btn_in = btn_in | mask;
        for (int i = 0; i < 3; i++) begin
            if (mask[i]) exp_level[i] = TMASK[i] ? ~exp_level[i] : 1'b1;
        end
        sb.push_back('{cyc: cyc + 3, pulse: mask, level: exp_level});
    endtask

    task automatic release_btn(input logic [2:0] mask);
        btn_in = btn_in & ~mask;
        exp_level = exp_level & ~(mask & ~TMASK);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 3'b000 && n < 60) begin
            tick();
            n++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        // 1: reset held with all buttons pressed
        reset  = 1'b1;
        btn_in = 3'b111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_pulse", 32'(pulse), 32'd0);
            check("rst_level", 32'(level), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        reset = 1'b0;
        press(3'b111);
        repeat (6) tick();
        check("busy_all_locked", 32'(busy), 32'h7);
        release_btn(3'b111);
        wait_idle();
        check("level_after_release", 32'(level), 32'(exp_level));

        // 2: clean press on ch0 held 40 cycles
        press(3'b001);
        repeat (3) tick();
        check("busy0_pulse_cycle", 32'(busy[0]), 32'd1);
        repeat (37) tick();
        check("busy0_held", 32'(busy[0]), 32'd1);
        release_btn(3'b001);
        repeat (2) tick();
        check("busy0_before_seen", 32'(busy[0]), 32'd1);
        tick();
        check("busy0_after_seen", 32'(busy[0]), 32'd0);
        check("level0_clean", 32'(level[0]), 32'(exp_level[0]));

        // 3: bouncy press on ch0, then a clean press
        press(3'b001);
        tick();
        for (int i = 0; i < 6; i++) begin
            btn_in[0] = (i % 2 == 1);
            tick();
        end
        repeat (15) tick();
        release_btn(3'b001);
        wait_idle();
        press(3'b001);
        repeat (10) tick();
        release_btn(3'b001);
        wait_idle();
        check("level0_after_second", 32'(level[0]), 32'(exp_level[0]));

        // 4: non-toggle ch1 follows held state
        press(3'b010);
        repeat (3) tick();
        check("level1_pulse_cycle", 32'(level[1]), 32'd1);
        repeat (17) tick();
        check("level1_held", 32'(level[1]), 32'd1);
        release_btn(3'b010);
        repeat (2) tick();
        check("level1_until_seen", 32'(level[1]), 32'd1);
        tick();
        check("level1_released", 32'(level[1]), 32'd0);
        wait_idle();

        // 5: simultaneous presses on ch0 and ch2
        press(3'b101);
        repeat (3) tick();
        check("busy_ch1_untouched", 32'(busy), 32'h5);
        repeat (12) tick();
        release_btn(3'b101);
        wait_idle();

        // 6: reset during lockout (cnt=4) with button held
        press(3'b001);
        repeat (6) tick();
        reset = 1'b1;
        tick();
        check("midrst_pulse", 32'(pulse), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        exp_level = 3'b000;
        reset = 1'b0;
        press(3'b001);
        repeat (5) tick();
        release_btn(3'b001);
        wait_idle();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
